sine_capture: RTL

- Downstream stage of the dual-output sine generator. Consumes the two sample streams (dout1, dout2) at the generator's enable rate.
- Arms, waits for a rising-level trigger on channel 1, then records DEPTH consecutive sample pairs into an internal buffer.
- Streams the captured pairs out over a valid/ready interface to a readout/display consumer. This is a one-shot, scope-style capture.

---
 rtl/sine_capture_pkg.sv | 24 ++
 rtl/sine_capture_ram.sv | 36 +++
 rtl/sine_capture.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sine_capture_pkg.sv
// sine_capture_pkg
// Shared definitions for the one-shot scope-style sample capture block:
// the controller state encoding, default sample/address widths and the
// buffer depth derivation used by both the controller and its RAM.
package sine_capture_pkg;

  localparam int D_WIDTH_DEFAULT = 8;
  localparam int A_WIDTH_DEFAULT = 8;

  // Buffer depth is always a power of two so the pointers never need a modulo.
  function automatic int depth_for(input int a_width);
    return 2 ** a_width;
  endfunction

  localparam int DEPTH_DEFAULT = depth_for(A_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/sine_capture_ram.sv
// capture_ram
// Simple dual-port sample buffer holding {din1, din2} pairs.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data ({ch1, ch2})
//   raddr  - read address
//   rdata  - read data, registered: reflects mem[raddr] one clock later
module capture_ram
  import sine_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 2 * D_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = A_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_for(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sine_capture.sv
// sine_capture
// One-shot capture of the two sine generator channels. After arm the block
// waits for a rising crossing of trig_level on din1 (or force_trig), records
// DEPTH consecutive sample pairs, then streams them out over valid/ready.
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   en                    - sample strobe shared with the generator
//   din1, din2            - channel samples
//   trig_level            - unsigned trigger threshold on din1
//   arm                   - start request (honoured only in IDLE)
//   force_trig            - trigger on the next en regardless of level
//   armed, busy, done     - status; done pulses once after the last transfer
//   rd_valid, rd_ready    - readout handshake
//   rd_data1, rd_data2    - captured pair being presented
//   rd_last               - presented entry is index DEPTH-1
module sine_capture
  import sine_capture_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEFAULT,
  parameter int A_WIDTH = A_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din1,
  input  logic [D_WIDTH-1:0] din2,
  input  logic [D_WIDTH-1:0] trig_level,
  input  logic               arm,
  input  logic               force_trig,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [D_WIDTH-1:0] rd_data1,
  output logic [D_WIDTH-1:0] rd_data2,
  output logic               rd_last
);

  localparam int DEPTH = depth_for(A_WIDTH);
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

  state_t               state;
  logic [A_WIDTH-1:0]   wr_ptr;
  logic [A_WIDTH-1:0]   rd_ptr;
  logic [D_WIDTH-1:0]   prev1;
  logic                 prev_valid;
  logic                 prime;
  logic                 load;
  logic                 trigger;
  logic                 ram_we;
  logic [A_WIDTH-1:0]   ram_waddr;
  logic [2*D_WIDTH-1:0] ram_rdata;

  // A level trigger needs a previous sample from this arming, so the first
  // strobe after arm can only fire through force_trig.
  assign trigger = en && (force_trig ||
                          (prev_valid && (prev1 < trig_level) && (din1 >= trig_level)));

  // The triggering sample itself becomes entry 0.
  assign ram_we    = ((state == ARMED) && trigger) || ((state == CAPTURE) && en);
  assign ram_waddr = (state == ARMED) ? '0 : wr_ptr;

  capture_ram #(
    .DATA_WIDTH (2 * D_WIDTH),
    .ADDR_WIDTH (A_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata ({din1, din2}),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Readout pipeline: prime gives the RAM its first read cycle, load copies
  // the RAM output into the presentation registers. rd_ptr advances on load
  // so the next entry is already fetched when the current one transfers,
  // which leaves exactly one bubble cycle between transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      prev1      <= '0;
      prev_valid <= 1'b0;
      prime      <= 1'b0;
      load       <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data1   <= '0;
      rd_data2   <= '0;
      rd_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state      <= ARMED;
            armed      <= 1'b1;
            busy       <= 1'b1;
            prev_valid <= 1'b0;
          end
        end
        ARMED: begin
          if (en) begin
            prev1      <= din1;
            prev_valid <= 1'b1;
            if (trigger) begin
              wr_ptr <= A_WIDTH'(1);
              state  <= CAPTURE;
              armed  <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (en) begin
            if (wr_ptr == LAST_ADDR) begin
              state  <= READOUT;
              rd_ptr <= '0;
              prime  <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        READOUT: begin
          prime <= 1'b0;
          if (prime) begin
            load <= 1'b1;
          end
          if (load) begin
            load     <= 1'b0;
            rd_valid <= 1'b1;
            rd_data1 <= ram_rdata[2*D_WIDTH-1:D_WIDTH];
            rd_data2 <= ram_rdata[D_WIDTH-1:0];
            rd_last  <= (rd_ptr == LAST_ADDR);
            if (rd_ptr != LAST_ADDR) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
          if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_last) begin
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              wr_ptr <= '0;
              rd_ptr <= '0;
            end else begin
              load <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
